// File: rtl/tron_fetch_unit.sv
// tron_fetch_unit: instruction-side partner of the multicycle controller.
// Owns PC and IR, drives the imem address (= next PC), and resolves
// pcAdd/pcJump/pcBranch using the condition code captured during FETCH.
module tron_fetch_unit #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetchPhase,
    input  logic                  pcAdd,
    input  logic                  pcJump,
    input  logic                  pcBranch,
    input  logic [3:0]            flagOp,
    input  logic [7:0]            immediate,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    input  logic [4:0]            flags,
    input  logic [15:0]           imem_rdata,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [15:0]           instruction,
    output logic [7:0]            instructionOp,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus1,
    output logic                  taken
);

    // Fields that are only driven by the controller during FETCH.
    typedef struct packed {
        logic [3:0] cond;
        logic [7:0] imm;
    } fetch_lat_t;

    logic [15:0]           ir;
    fetch_lat_t            lat_q;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [ADDR_WIDTH-1:0] br_target;
    logic                  cond;

    // flags = {C,L,F,Z,N}
    function automatic logic eval_cond(input logic [3:0] cc, input logic [4:0] f);
        logic c, l, fl, z, n;
        {c, l, fl, z, n} = f;
        case (cc)
            4'b0000: return z;
            4'b0001: return !z;
            4'b0010: return c;
            4'b0011: return !c;
            4'b0100: return l;
            4'b0101: return !l;
            4'b0110: return n;
            4'b0111: return !n;
            4'b1000: return fl;
            4'b1001: return !fl;
            4'b1010: return !l && !z;
            4'b1011: return l || z;
            4'b1100: return !n && !z;
            4'b1101: return n || z;
            default: return 1'b1;
        endcase
    endfunction

    // Controller-facing opcode: register-form ops keep their ext nibble,
    // shifts collapse to LSH (0x84) or LSHI with the direction bit.
    function automatic logic [7:0] decode_op(input logic [15:0] w);
        logic [3:0] op, ext;
        op  = w[15:12];
        ext = w[7:4];
        if (op == 4'b0000 || op == 4'b0100) return {op, ext};
        else if (op == 4'b1000) return (ext == 4'b0100) ? 8'h84 : {4'h8, 3'b000, w[4]};
        else return {op, 4'h0};
    endfunction

    assign pc_plus1      = pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    assign br_target     = pc + {{(ADDR_WIDTH-8){lat_q.imm[7]}}, lat_q.imm};
    assign cond          = eval_cond(lat_q.cond, flags);
    assign instruction   = fetchPhase ? imem_rdata : ir;
    assign instructionOp = decode_op(instruction);
    assign imem_addr     = pc_next;

    // Next-PC select; during reset the imem is pointed at RESET_PC so the
    // first FETCH after release sees valid data.
    always_comb begin
        pc_next = pc;
        if (!reset)        pc_next = RESET_PC;
        else if (pcJump)   pc_next = cond ? jump_target : pc_plus1;
        else if (pcBranch) pc_next = cond ? br_target : pc_plus1;
        else if (pcAdd)    pc_next = pc_plus1;
    end

    // PC, IR, FETCH-latched fields and taken flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc    <= RESET_PC;
            ir    <= '0;
            lat_q <= '0;
            taken <= 1'b0;
        end else begin
            pc    <= pc_next;
            taken <= (pcJump || pcBranch) && cond;
            if (fetchPhase) begin
                ir        <= imem_rdata;
                lat_q.cond <= flagOp;
                lat_q.imm  <= immediate;
            end
        end
    end

endmodule
